nibble_serial_comparator: RTL and testbench

- Sequential controller that compares two wide unsigned operands one nibble at a time, MSB nibble first.
- It drives a 4-bit pair into the team's combinational 4-bit magnitude comparator and consumes that comparator's AgtB/AltB/AeqB flags in the same cycle.
- It sits directly upstream of the comparator, feeding it nibbles, and directly downstream of it, consuming its flags. It turns a 4-bit comparator into an N×4-bit comparator with early termination.

---
 rtl/nibble_serial_comparator.sv | 139 +++++++++++++
 tb/tb_nibble_serial_comparator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_comparator.sv
// Serial N x 4-bit magnitude compare, MSB nibble first, with early exit.
// Drives an external 4-bit comparator and consumes its flags the same cycle.
module nibble_serial_comparator #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   a_in,
   input  logic [4*NIBBLES-1:0]   b_in,
   output logic                   busy,
   output logic                   done,
   output logic                   gt,
   output logic                   lt,
   output logic                   eq,
   output logic                   err,
   output logic [3:0]             cmp_a,
   output logic [3:0]             cmp_b,
   input  logic                   cmp_gt,
   input  logic                   cmp_lt,
   input  logic                   cmp_eq
);

   localparam int IW = $clog2(NIBBLES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   state_t               state_nx;
   logic [4*NIBBLES-1:0] a_reg;
   logic [4*NIBBLES-1:0] b_reg;
   logic [IW-1:0]        idx;

   logic f_gt;
   logic f_lt;
   logic f_eq;
   logic last;

   // A flag set is legal only when exactly one flag is raised.
   always_comb begin
      f_gt = ({cmp_gt, cmp_lt, cmp_eq} == 3'b100);
      f_lt = ({cmp_gt, cmp_lt, cmp_eq} == 3'b010);
      f_eq = ({cmp_gt, cmp_lt, cmp_eq} == 3'b001);
      last = (idx == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         a_reg <= '0;
         b_reg <= '0;
         idx   <= '0;
         gt    <= 1'b0;
         lt    <= 1'b0;
         eq    <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= a_in;
                  b_reg <= b_in;
                  idx   <= IW'(NIBBLES - 1);
                  gt    <= 1'b0;
                  lt    <= 1'b0;
                  eq    <= 1'b0;
                  err   <= 1'b0;
               end
            end
            SCAN: begin
               if (f_gt) begin
                  gt <= 1'b1;
               end else if (f_lt) begin
                  lt <= 1'b1;
               end else if (f_eq) begin
                  if (last) begin
                     eq <= 1'b1;
                  end else begin
                     idx <= idx - 1'b1;
                  end
               end else begin
                  err <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nx = SCAN;
            end
         end
         SCAN: begin
            if (!(f_eq && !last)) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Nibble pair comes only from captured operands, never from a_in/b_in.
   always_comb begin
      busy  = 1'b0;
      done  = 1'b0;
      cmp_a = 4'h0;
      cmp_b = 4'h0;
      unique case (state)
         SCAN: begin
            busy  = 1'b1;
            cmp_a = a_reg[{idx, 2'b00} +: 4];
            cmp_b = b_reg[{idx, 2'b00} +: 4];
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// Directed bench: closes the loop with a 4-bit magnitude comparator model
// around NIBBLES=4 and NIBBLES=2 instances; includes a faulty-comparator stub.
module tb_nibble_serial_comparator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic stub = 1'b0;
   logic sel2 = 1'b0;

   always #5 clk = ~clk;

   logic        start4 = 1'b0;
   logic [15:0] a4 = '0;
   logic [15:0] b4 = '0;
   logic        busy4, done4, gt4, lt4, eq4, err4;
   logic [3:0]  ca4, cb4;
   logic        cg4, cl4, ce4;

   logic        start2 = 1'b0;
   logic [7:0]  a2 = '0;
   logic [7:0]  b2 = '0;
   logic        busy2, done2, gt2, lt2, eq2, err2;
   logic [3:0]  ca2, cb2;
   logic        cg2, cl2, ce2;

   assign cg4 = stub ? 1'b1 : (ca4 > cb4);
   assign cl4 = stub ? 1'b1 : (ca4 < cb4);
   assign ce4 = stub ? 1'b0 : (ca4 == cb4);
   assign cg2 = (ca2 > cb2);
   assign cl2 = (ca2 < cb2);
   assign ce2 = (ca2 == cb2);

   nibble_serial_comparator #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4),
      .busy(busy4), .done(done4), .gt(gt4), .lt(lt4), .eq(eq4),
      .err(err4), .cmp_a(ca4), .cmp_b(cb4),
      .cmp_gt(cg4), .cmp_lt(cl4), .cmp_eq(ce4)
   );

   nibble_serial_comparator #(.NIBBLES(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .a_in(a2), .b_in(b2),
      .busy(busy2), .done(done2), .gt(gt2), .lt(lt2), .eq(eq2),
      .err(err2), .cmp_a(ca2), .cmp_b(cb2),
      .cmp_gt(cg2), .cmp_lt(cl2), .cmp_eq(ce2)
   );

   wire       busy_s = sel2 ? busy2 : busy4;
   wire       done_s = sel2 ? done2 : done4;
   wire [3:0] res_s  = sel2 ? {gt2, lt2, eq2, err2} : {gt4, lt4, eq4, err4};
   wire [3:0] ca_s   = sel2 ? ca2 : ca4;
   wire [3:0] cb_s   = sel2 ? cb2 : cb4;

   localparam logic [3:0] R_GT  = 4'b1000;
   localparam logic [3:0] R_LT  = 4'b0100;
   localparam logic [3:0] R_EQ  = 4'b0010;
   localparam logic [3:0] R_ERR = 4'b0001;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [15:0] a,
                        input logic [15:0] b);
      if (sel2) begin
         start2 = s;
         a2 = a[7:0];
         b2 = b[7:0];
      end else begin
         start4 = s;
         a4 = a;
         b4 = b;
      end
   endtask

   // One compare: expects k nibbles examined and result res.
   // rep keeps start high and scrambles the operands while busy.
   task automatic run(input string tag, input logic [15:0] a,
                      input logic [15:0] b, input int k,
                      input logic [3:0] res, input bit rep);
      int n;
      int nib;
      int nibs;
      logic [15:0] sa;
      logic [15:0] sb;
      nibs = sel2 ? 2 : 4;
      drive(1'b1, a, b);
      tick();
      n = 1;
      if (rep) drive(1'b1, ~a, ~b);
      else drive(1'b0, a, b);
      check({tag, ".clr"}, 32'(res_s), 32'h0);
      check({tag, ".busy"}, 32'(busy_s), 32'h1);
      while (!done_s && n < 40) begin
         nib = nibs - n;
         if (nib >= 0) begin
            sa = a >> (4 * nib);
            sb = b >> (4 * nib);
            check($sformatf("%s.cmp_a%0d", tag, n), 32'(ca_s), 32'(sa[3:0]));
            check($sformatf("%s.cmp_b%0d", tag, n), 32'(cb_s), 32'(sb[3:0]));
         end
         tick();
         n++;
      end
      check({tag, ".edges"}, 32'(n), 32'(k + 1));
      check({tag, ".res"}, 32'(res_s), 32'(res));
      check({tag, ".dbusy"}, 32'(busy_s), 32'h1);
      check({tag, ".dcmp"}, 32'({ca_s, cb_s}), 32'h0);
      tick();
      drive(1'b0, a, b);
      check({tag, ".pulse"}, 32'(done_s), 32'h0);
      check({tag, ".idle"}, 32'(busy_s), 32'h0);
      check({tag, ".hold"}, 32'(res_s), 32'(res));
      tick();
      check({tag, ".nostart"}, 32'(busy_s), 32'h0);
      check({tag, ".hold2"}, 32'(res_s), 32'(res));
   endtask

   initial begin
      // Reset with a start pulse that must be ignored.
      rst = 1'b1;
      tick();
      start4 = 1'b1;
      a4 = 16'h1234;
      b4 = 16'h0FFF;
      tick();
      start4 = 1'b0;
      rst = 1'b0;
      check("rst.busy", 32'(busy4), 32'h0);
      check("rst.done", 32'(done4), 32'h0);
      check("rst.res", 32'({gt4, lt4, eq4, err4}), 32'h0);
      check("rst.cmp", 32'({ca4, cb4}), 32'h0);
      tick();
      check("rst.idle", 32'(busy4), 32'h0);

      run("gt_1nib", 16'h1234, 16'h0FFF, 1, R_GT, 1'b0);
      run("lt_4nib", 16'hC3A5, 16'hC3A6, 4, R_LT, 1'b0);
      run("eq_rep", 16'hC3A5, 16'hC3A5, 4, R_EQ, 1'b1);
      run("eq_zero", 16'h0000, 16'h0000, 4, R_EQ, 1'b0);
      run("gt_ffff", 16'hFFFF, 16'h0000, 1, R_GT, 1'b1);
      run("lt_last", 16'h8000, 16'h8001, 4, R_LT, 1'b0);

      // Abort in the third SCAN cycle.
      drive(1'b1, 16'hC3A5, 16'hC3A6);
      tick();
      drive(1'b0, 16'hC3A5, 16'hC3A6);
      tick();
      tick();
      check("abort.cmp", 32'({ca4, cb4}), 32'hAA);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort.busy", 32'(busy4), 32'h0);
      check("abort.done", 32'(done4), 32'h0);
      check("abort.res", 32'({gt4, lt4, eq4, err4}), 32'h0);
      check("abort.cmp0", 32'({ca4, cb4}), 32'h0);
      tick();
      check("abort.nodone", 32'(done4), 32'h0);
      run("after_abort", 16'hC3A5, 16'hC3A6, 4, R_LT, 1'b0);

      stub = 1'b1;
      run("stub_err", 16'h5555, 16'h5555, 1, R_ERR, 1'b0);
      stub = 1'b0;
      run("after_stub", 16'h0001, 16'h0002, 4, R_LT, 1'b0);

      sel2 = 1'b1;
      run("n2_eq", 16'h00A5, 16'h00A5, 2, R_EQ, 1'b0);
      run("n2_lt", 16'h005A, 16'h00A5, 1, R_LT, 1'b0);
      run("n2_gt", 16'h00A6, 16'h00A5, 2, R_GT, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
